// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op and state encodings for the RV M-extension multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide, one shift-add or restoring-divide step per cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  muldiv_state_t state, state_n;
  muldiv_op_t op, op_in;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] acc, step, prod;
  logic [XLEN-1:0] b_mag, a_mag, fast_res, calc_res, quo, rem;
  logic [XLEN:0] mul_sum, div_diff;
  logic neg_q, neg_r, fast_q, a_neg, b_neg, div0, ovf, fast, accept, last;
  assign op_in    = muldiv_op_t'(funct3);
  assign a_neg    = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src_a[XLEN-1];
  assign b_neg    = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && src_b[XLEN-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign div0     = funct3[2] && src_b == '0;
  assign ovf      = funct3[2] && !funct3[0] && src_a == {1'b1, {(XLEN-1){1'b0}}} && &src_b;
  assign fast     = div0 || ovf;
  assign fast_res = div0 ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : src_a);
  assign ready    = state != S_CALC;
  assign busy     = state == S_CALC;
  assign done     = state == S_DONE;
  assign accept   = start && ready && !flush;
  // The extra CALC cycle at cnt==XLEN applies sign correction off the iteration path
  assign last     = fast_q || cnt == CNT_W'(XLEN);
  // acc is {upper, lower}: product high/low for multiply, remainder/quotient for divide
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign div_diff = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, b_mag};
  assign step     = op[2] ? (div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                            : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                          : {mul_sum, acc[XLEN-1:1]};
  assign prod     = neg_q ? -acc : acc;
  assign quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign calc_res = op[2] ? (op[1] ? rem : quo)
                          : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_n = flush ? S_IDLE
            : accept ? S_CALC
            : (state == S_CALC && !last) ? S_CALC
            : (state == S_CALC) ? S_DONE
            : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
      acc    <= '0;
      b_mag  <= '0;
      op     <= OP_MUL;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      fast_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op     <= op_in;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        fast_q <= fast;
        cnt    <= '0;
        b_mag  <= b_neg ? -src_b : src_b;
        acc    <= {{XLEN{1'b0}}, fast ? fast_res : a_mag};
      end else if (state == S_CALC && !flush) begin
        if (last) result <= fast_q ? acc[XLEN-1:0] : calc_res;
        else begin
          acc <= step;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at XLEN=32
module tb_muldiv_unit;
  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [6:0]  lat;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic ready, busy, done;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .src_a(src_a),
    .src_b(src_b), .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    funct3 = f; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f; src_a = 32'hDEADBEEF; src_b = 32'h12345678;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result;
    if (!done) lat = -1;
  endtask
  task automatic run_table(input string name, input vec_t v[]);
    logic [31:0] res;
    int lat;
    foreach (v[i]) begin
      run_op(v[i].f, v[i].a, v[i].b, res, lat);
      tests++;
      if (res !== v[i].r || lat != int'(v[i].lat)) begin
        fails++;
        $display("FAIL %s[%0d]: got result=%h latency=%0d, want result=%h latency=%0d",
                 name, i, res, lat, v[i].r, v[i].lat);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL %s[%0d]_single_done: got done=%b want 0", name, i, done);
      end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset: got rdy=%b busy=%b done=%b res=%h want 1 0 0 0", ready, busy, done, result);
    end
    reset = 1'b0;
  endtask
  task automatic test_mul;
    vec_t v[];
    v = '{
      '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 7'd33},
      '{3'd0, 32'd123,      32'd456,      32'h0000DB18, 7'd33},
      '{3'd0, 32'd0,        32'h12345678, 32'h00000000, 7'd33},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 7'd33},
      '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 7'd33},
      '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'd33},
      '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 7'd33},
      '{3'd2, 32'h80000000, 32'd2,        32'hFFFFFFFF, 7'd33}
    };
    run_table("mul", v);
  endtask
  task automatic test_div;
    vec_t v[];
    v = '{
      '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 7'd33},
      '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 7'd33},
      '{3'd5, 32'd100,      32'd7,        32'd14,       7'd33},
      '{3'd7, 32'd100,      32'd7,        32'd2,        7'd33},
      '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 7'd33},
      '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        7'd33},
      '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        7'd33},
      '{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 7'd33}
    };
    run_table("div", v);
  endtask
  task automatic test_div_fast;
    vec_t v[];
    v = '{
      '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 7'd1},
      '{3'd6, 32'd5,        32'd0,        32'd5,        7'd1},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 7'd1},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        7'd1},
      '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 7'd1},
      '{3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 7'd1}
    };
    run_table("div_fast", v);
  endtask
  task automatic test_busy_start;
    int lat;
    funct3 = 3'd0; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    funct3 = 3'd0; src_a = 32'd100; src_b = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_start_busy: got busy=%b want 1", busy); end
    lat = 5;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (result !== 32'd15 || lat != 33) begin
      fails++;
      $display("FAIL busy_start: got result=%h latency=%0d want result=0000000f latency=33", result, lat);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_flush;
    bit seen = 0;
    funct3 = 3'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    tests++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: got rdy=%b busy=%b want 1 0", ready, busy);
    end
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1; end
    tests++;
    if (seen || result !== 32'd15) begin
      fails++;
      $display("FAIL flush_no_done: got done_seen=%b result=%h want 0 0000000f", seen, result);
    end
    flush = 1'b1; start = 1'b1; funct3 = 3'd0; src_a = 32'd2; src_b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_beats_start: got busy=%b rdy=%b want 0 1", busy, ready);
    end
  endtask
  task automatic test_reset_mid;
    bit seen = 0;
    funct3 = 3'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1; flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    tests++;
    if ({ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid: got rdy=%b busy=%b done=%b res=%h want 1 0 0 0", ready, busy, done, result);
    end
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL reset_mid_quiet: got activity=1 want 0"); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    run_op(3'd0, 32'd6, 32'd7, res, lat);
    funct3 = 3'd5; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tests++;
    if (done !== 1'b1 || result !== 32'd42 || lat != 33) begin
      fails++;
      $display("FAIL b2b_first: got done=%b result=%h latency=%0d want 1 0000002a 33", done, result, lat);
    end
    @(posedge clk); #1;
    start = 1'b0; src_a = 32'd0; src_b = 32'd0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
    end
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (result !== 32'd14 || lat != 33) begin
      fails++;
      $display("FAIL b2b_second: got result=%h latency=%0d want 0000000e 33", result, lat);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_fast;
    test_busy_start;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
